// File: rtl/l_arb_pkg.sv
`default_nettype none
// ============================================================================
// l_arb_pkg : shared types and defaults for the L-function arbiter
// Revision  : 1.0
// ============================================================================
package l_arb_pkg;

   localparam int K_DEF       = 128;
   localparam int N_DEF       = 32;
   localparam int REQ_DEF     = 4;
   localparam int TIMEOUT_DEF = 4096;
   localparam int ID_W_DEF    = $clog2(REQ_DEF);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_LOAD  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } l_arb_state_e;

   typedef struct packed {
      logic [ID_W_DEF-1:0] id;
      logic [K_DEF-1:0]    data;
      logic                err;
   } rsp_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin grant searching upward from ptr_i
// Revision   : 1.0
// ============================================================================
module rr_arbiter #(
   parameter  int REQ = 4,
   localparam int PW  = (REQ > 1) ? $clog2(REQ) : 1
) (
   input  logic [REQ-1:0] req_i,
   input  logic [PW-1:0]  ptr_i,
   output logic [REQ-1:0] grant_o,
   output logic [PW-1:0]  grant_idx_o,
   output logic           grant_valid_o,
   output logic [PW-1:0]  ptr_next_o
);

   // ptr_i is always < REQ, so a single subtraction wraps the search index.
   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int offs);
      int sum;
      sum = int'(base) + offs;
      if (sum >= REQ) sum = sum - REQ;
      return PW'(sum);
   endfunction

   always_comb begin
      grant_o       = '0;
      grant_idx_o   = '0;
      grant_valid_o = 1'b0;
      for (int k = 0; k < REQ; k++) begin
         if (!grant_valid_o && req_i[wrap_idx(ptr_i, k)]) begin
            grant_o[wrap_idx(ptr_i, k)] = 1'b1;
            grant_idx_o                 = wrap_idx(ptr_i, k);
            grant_valid_o               = 1'b1;
         end
      end
   end

   assign ptr_next_o = (grant_idx_o == PW'(REQ - 1)) ? '0 : grant_idx_o + 1'b1;

endmodule
`default_nettype wire

// File: rtl/l_func_arbiter.sv
`default_nettype none
// ============================================================================
// l_func_arbiter : round-robin sharing of one L-function unit among REQ lanes
// Revision       : 1.0
// ============================================================================
module l_func_arbiter
   import l_arb_pkg::*;
#(
   parameter  int K       = K_DEF,
   parameter  int N       = N_DEF,
   parameter  int REQ     = REQ_DEF,
   parameter  int TIMEOUT = TIMEOUT_DEF,
   localparam int ID_W    = (REQ > 1) ? $clog2(REQ) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REQ-1:0]   req_valid_i,
   input  logic [REQ*K-1:0] req_x_i,
   output logic [REQ-1:0]   req_ready_o,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [ID_W-1:0]  rsp_id_o,
   output logic [K-1:0]     rsp_data_o,
   output logic             rsp_err_o,
   output logic             busy_o,
   output logic             l_task_start_o,
   output logic [K-1:0]     l_x_o,
   output logic             l_x_valid_o,
   input  logic [K-1:0]     l_out_i,
   input  logic             l_out_valid_i
);

   localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   if (REQ < 2 || N < 1 || TIMEOUT < 2) begin : g_bad_params
      $error("l_func_arbiter: REQ must be >= 2, N >= 1 and TIMEOUT >= 2");
   end

   l_arb_state_e    state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [K-1:0]    op_q, op_d;
   logic [ID_W-1:0] id_q, id_d;
   logic            task_start_q, task_start_d;
   logic            lxv_q, lxv_d;
   logic [K-1:0]    lx_q, lx_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic [K-1:0]    rsp_data_q, rsp_data_d;
   logic            rsp_err_q, rsp_err_d;
   logic            busy_q, busy_d;

   logic [REQ-1:0]  w_grant;
   logic [ID_W-1:0] w_gnt_idx;
   logic            w_gnt_valid;
   logic [ID_W-1:0] w_ptr_next;

   rr_arbiter #(.REQ(REQ)) u_rr (
      .req_i         (req_valid_i),
      .ptr_i         (rr_ptr_q),
      .grant_o       (w_grant),
      .grant_idx_o   (w_gnt_idx),
      .grant_valid_o (w_gnt_valid),
      .ptr_next_o    (w_ptr_next)
   );

   // The grant is only offered in IDLE, so every offered grant is accepted.
   assign req_ready_o = (state_q == ST_IDLE) ? w_grant : '0;

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      wd_d         = wd_q;
      op_d         = op_q;
      id_d         = id_q;
      task_start_d = 1'b0;
      lxv_d        = 1'b0;
      lx_d         = lx_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (w_gnt_valid) begin
               op_d         = req_x_i[int'(w_gnt_idx)*K +: K];
               id_d         = w_gnt_idx;
               rr_ptr_d     = w_ptr_next;
               task_start_d = 1'b1;
               state_d      = ST_START;
            end
         end
         ST_START: begin
            lxv_d   = 1'b1;
            lx_d    = op_q;
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            wd_d    = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A result arriving on the expiry cycle takes priority over the error.
            if (l_out_valid_i) begin
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_data_d  = l_out_i;
               rsp_err_d   = 1'b0;
               state_d     = ST_RESP;
            end else if (wd_q == WD_LAST) begin
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               state_d     = ST_RESP;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         wd_q         <= '0;
         op_q         <= '0;
         id_q         <= '0;
         task_start_q <= 1'b0;
         lxv_q        <= 1'b0;
         lx_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         wd_q         <= wd_d;
         op_q         <= op_d;
         id_q         <= id_d;
         task_start_q <= task_start_d;
         lxv_q        <= lxv_d;
         lx_q         <= lx_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         busy_q       <= busy_d;
      end
   end

   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_id_o       = rsp_id_q;
   assign rsp_data_o     = rsp_data_q;
   assign rsp_err_o      = rsp_err_q;
   assign busy_o         = busy_q;
   assign l_task_start_o = task_start_q;
   assign l_x_o          = lx_q;
   assign l_x_valid_o    = lxv_q;

endmodule
`default_nettype wire

// File: tb/tb_l_func_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_l_func_arbiter : directed scenarios plus randomized traffic checked
// against a transaction-level model. Revision: 1.0
// ============================================================================
module tb_l_func_arbiter;
   import l_arb_pkg::*;

   localparam int K   = 128;
   localparam int REQ = 4;
   localparam int IDW = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // main instance (default TIMEOUT)
   logic [REQ-1:0]   req_valid = '0;
   logic [REQ*K-1:0] req_x     = '0;
   logic             rsp_ready = 1'b1;
   logic [REQ-1:0]   req_ready;
   logic             rsp_valid, rsp_err, busy, l_task_start, l_x_valid;
   logic [IDW-1:0]   rsp_id;
   logic [K-1:0]     rsp_data, l_x;
   logic [K-1:0]     l_out = '0;
   logic             mdl_v = 1'b0;
   logic             spur_v = 1'b0;
   wire              l_out_valid = mdl_v | spur_v;

   // short-watchdog instance
   logic [REQ-1:0]   wd_req_valid = '0;
   logic [REQ*K-1:0] wd_req_x     = '0;
   logic             wd_rsp_ready = 1'b1;
   logic [REQ-1:0]   wd_req_ready;
   logic             wd_rsp_valid, wd_rsp_err, wd_busy, wd_l_task_start, wd_l_x_valid;
   logic [IDW-1:0]   wd_rsp_id;
   logic [K-1:0]     wd_rsp_data, wd_l_x;
   logic [K-1:0]     wd_l_out = '0;
   logic             wd_l_out_valid = 1'b0;

   l_func_arbiter u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_x_i(req_x), .req_ready_o(req_ready),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
      .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .busy_o(busy),
      .l_task_start_o(l_task_start), .l_x_o(l_x), .l_x_valid_o(l_x_valid),
      .l_out_i(l_out), .l_out_valid_i(l_out_valid)
   );

   l_func_arbiter #(.TIMEOUT(16)) u_wd (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(wd_req_valid), .req_x_i(wd_req_x), .req_ready_o(wd_req_ready),
      .rsp_valid_o(wd_rsp_valid), .rsp_ready_i(wd_rsp_ready), .rsp_id_o(wd_rsp_id),
      .rsp_data_o(wd_rsp_data), .rsp_err_o(wd_rsp_err), .busy_o(wd_busy),
      .l_task_start_o(wd_l_task_start), .l_x_o(wd_l_x), .l_x_valid_o(wd_l_x_valid),
      .l_out_i(wd_l_out), .l_out_valid_i(wd_l_out_valid)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int ref_ptr = 0;
   int wd_ptr  = 0;

   // L-unit model: answers mdl_lat cycles after the operand strobe (0 = never)
   int           mdl_lat = 0;
   bit           mdl_fixed_en = 1'b0;
   logic [K-1:0] mdl_fixed = '0;
   bit           mdl_pend = 1'b0;
   int           mdl_cnt = 0;
   logic [K-1:0] mdl_res = '0;

   function automatic logic [K-1:0] lfunc(input logic [K-1:0] x);
      return (x - 1) / 3;
   endfunction

   function automatic int ref_grant(input logic [REQ-1:0] v, input int p);
      for (int k = 0; k < REQ; k++)
         if (v[(p + k) % REQ]) return (p + k) % REQ;
      return -1;
   endfunction

   function automatic logic [REQ-1:0] onehot(input int idx);
      logic [REQ-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [K-1:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         mdl_v = 1'b0;
         if (!rst_n) begin
            mdl_pend = 1'b0;
         end else begin
            if (mdl_pend) begin
               mdl_cnt--;
               if (mdl_cnt == 0) begin
                  mdl_v    = 1'b1;
                  l_out    = mdl_res;
                  mdl_pend = 1'b0;
               end
            end
            if (l_x_valid) begin
               mdl_pend = (mdl_lat > 0);
               mdl_cnt  = mdl_lat;
               mdl_res  = mdl_fixed_en ? mdl_fixed : lfunc(l_x);
            end
         end
      end
   end

   task automatic wait_rsp(input int limit, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < limit) begin
         @(negedge clk);
         n++;
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req_valid = '0; wd_req_valid = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({req_ready, rsp_valid, rsp_id, rsp_err, busy, l_task_start, l_x_valid} !== '0) begin
         n_bad++; $display("FAIL reset_ctrl: got %b want all zero", {req_ready, rsp_valid, rsp_id, rsp_err, busy, l_task_start, l_x_valid}); end
      n_cmp++; if ({rsp_data, l_x} !== '0) begin
         n_bad++; $display("FAIL reset_data: got %h/%h want 0/0", rsp_data, l_x); end
      rst_n = 1'b1; ref_ptr = 0; wd_ptr = 0;
      @(negedge clk);
      n_cmp++; if ({req_ready, rsp_valid, busy, l_task_start, l_x_valid, rsp_data} !== '0) begin
         n_bad++; $display("FAIL reset_release_idle: got %h want 0", {req_ready, rsp_valid, busy, l_task_start, l_x_valid, rsp_data}); end
      n_cmp++; if ({wd_req_ready, wd_rsp_valid, wd_busy, wd_rsp_data} !== '0) begin
         n_bad++; $display("FAIL reset_wd_idle: got %h want 0", {wd_req_ready, wd_rsp_valid, wd_busy, wd_rsp_data}); end
   endtask

   task automatic test_single;
      logic [K-1:0] x;
      int n; bit ok;
      x = {32'hCAFE_F00D, 84'h0, 12'h0A3};
      mdl_lat = 20; mdl_fixed_en = 1'b1; mdl_fixed = 128'h55; rsp_ready = 1'b1;
      req_x[2*K +: K] = x; req_valid = 4'b0100;
      #1;
      n_cmp++; if (req_ready !== onehot(ref_grant(req_valid, ref_ptr))) begin
         n_bad++; $display("FAIL single_grant: got %b want %b", req_ready, onehot(ref_grant(req_valid, ref_ptr))); end
      ref_ptr = 3;
      @(negedge clk); req_valid = '0;
      n_cmp++; if ({l_task_start, l_x_valid, busy, req_ready} !== {1'b1, 1'b0, 1'b1, 4'b0000}) begin
         n_bad++; $display("FAIL single_start: got %b want 1010000", {l_task_start, l_x_valid, busy, req_ready}); end
      @(negedge clk);
      n_cmp++; if ({l_task_start, l_x_valid, l_x} !== {1'b0, 1'b1, x}) begin
         n_bad++; $display("FAIL single_load: got start=%b xv=%b x=%h want 0 1 %h", l_task_start, l_x_valid, l_x, x); end
      wait_rsp(40, n, ok);
      n_cmp++; if (!ok || n != 21) begin
         n_bad++; $display("FAIL single_latency: got ok=%0d n=%0d want ok=1 n=21", ok, n); end
      n_cmp++; if ({rsp_id, rsp_data, rsp_err} !== {2'd2, 128'h55, 1'b0}) begin
         n_bad++; $display("FAIL single_rsp: got id=%0d data=%h err=%b want 2 55 0", rsp_id, rsp_data, rsp_err); end
      @(negedge clk);
      n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin
         n_bad++; $display("FAIL single_idle: got %b want 00", {rsp_valid, busy}); end
      mdl_fixed_en = 1'b0;
   endtask

   task automatic test_all_lanes;
      logic [K-1:0] xs [REQ];
      int g, n; bit ok;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1; ref_ptr = 0; wd_ptr = 0;
      for (int i = 0; i < REQ; i++) begin
         xs[i] = rand128();
         req_x[i*K +: K] = xs[i];
      end
      req_valid = '1; rsp_ready = 1'b1;
      for (int t = 0; t < 5; t++) begin
         mdl_lat = $urandom_range(2, 6);
         #1;
         g = ref_grant(req_valid, ref_ptr);
         n_cmp++; if (req_ready !== onehot(g) || g != (t % REQ)) begin
            n_bad++; $display("FAIL all_lanes_grant%0d: got %b want %b", t, req_ready, onehot(t % REQ)); end
         ref_ptr = (g + 1) % REQ;
         wait_rsp(40, n, ok);
         n_cmp++; if (!ok || {rsp_id, rsp_data, rsp_err} !== {IDW'(g), lfunc(xs[g]), 1'b0}) begin
            n_bad++; $display("FAIL all_lanes_rsp%0d: got ok=%0d id=%0d data=%h err=%b want id=%0d data=%h", t, ok, rsp_id, rsp_data, rsp_err, g, lfunc(xs[g])); end
         @(negedge clk);
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure;
      logic [K-1:0] x;
      int lane, g, n; bit ok;
      lane = $urandom_range(0, REQ-1); x = rand128();
      req_x[lane*K +: K] = x; req_valid = onehot(lane);
      rsp_ready = 1'b0; mdl_lat = 5;
      #1;
      g = ref_grant(req_valid, ref_ptr);
      n_cmp++; if (req_ready !== onehot(g)) begin
         n_bad++; $display("FAIL bp_grant: got %b want %b", req_ready, onehot(g)); end
      ref_ptr = (g + 1) % REQ;
      @(negedge clk); req_valid = '1;
      wait_rsp(40, n, ok);
      n_cmp++; if (!ok) begin
         n_bad++; $display("FAIL bp_timeout: got no rsp_valid want rsp_valid"); end
      for (int c = 0; c < 10; c++) begin
         n_cmp++; if ({rsp_valid, rsp_id, rsp_data, rsp_err, req_ready, l_task_start} !== {1'b1, IDW'(g), lfunc(x), 1'b0, 4'b0000, 1'b0}) begin
            n_bad++; $display("FAIL bp_hold%0d: got v=%b id=%0d data=%h err=%b rdy=%b st=%b want 1 %0d %h 0 0000 0", c, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready, l_task_start, g, lfunc(x)); end
         @(negedge clk);
      end
      rsp_ready = 1'b1; req_valid = '0;
      @(negedge clk);
      n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin
         n_bad++; $display("FAIL bp_release: got %b want 00", {rsp_valid, busy}); end
   endtask

   task automatic test_spurious;
      logic [K-1:0] x;
      int lane, g, n; bit ok;
      spur_v = 1'b1;
      @(negedge clk); spur_v = 1'b0;
      n_cmp++; if ({busy, rsp_valid, l_task_start} !== 3'b000) begin
         n_bad++; $display("FAIL spur_idle: got %b want 000", {busy, rsp_valid, l_task_start}); end
      lane = $urandom_range(0, REQ-1); x = rand128();
      req_x[lane*K +: K] = x; req_valid = onehot(lane); mdl_lat = 8; rsp_ready = 1'b1;
      #1;
      g = ref_grant(req_valid, ref_ptr);
      n_cmp++; if (req_ready !== onehot(g)) begin
         n_bad++; $display("FAIL spur_grant: got %b want %b", req_ready, onehot(g)); end
      ref_ptr = (g + 1) % REQ;
      @(negedge clk); req_valid = '0; spur_v = 1'b1;
      @(negedge clk); spur_v = 1'b0;
      n_cmp++; if ({l_x_valid, rsp_valid} !== 2'b10) begin
         n_bad++; $display("FAIL spur_start: got %b want 10", {l_x_valid, rsp_valid}); end
      wait_rsp(40, n, ok);
      n_cmp++; if (!ok || n != 9 || {rsp_id, rsp_data, rsp_err} !== {IDW'(g), lfunc(x), 1'b0}) begin
         n_bad++; $display("FAIL spur_rsp: got ok=%0d n=%0d id=%0d data=%h err=%b want 1 9 %0d %h 0", ok, n, rsp_id, rsp_data, rsp_err, g, lfunc(x)); end
      @(negedge clk);
   endtask

   task automatic test_watchdog;
      logic [K-1:0] x, val;
      int lane, g, n;
      wd_rsp_ready = 1'b1; wd_l_out_valid = 1'b0;
      // hung L unit
      lane = $urandom_range(0, REQ-1); x = rand128();
      wd_req_x = '0; wd_req_x[lane*K +: K] = x; wd_req_valid = onehot(lane);
      #1;
      g = ref_grant(wd_req_valid, wd_ptr);
      n_cmp++; if (wd_req_ready !== onehot(g)) begin
         n_bad++; $display("FAIL wd_grant: got %b want %b", wd_req_ready, onehot(g)); end
      wd_ptr = (g + 1) % REQ;
      @(negedge clk); wd_req_valid = '0; n = 1;
      while (!wd_rsp_valid && n < 40) begin
         @(negedge clk); n++;
      end
      n_cmp++; if (!wd_rsp_valid || n != 19) begin
         n_bad++; $display("FAIL wd_expiry_time: got v=%b n=%0d want v=1 n=19", wd_rsp_valid, n); end
      n_cmp++; if ({wd_rsp_id, wd_rsp_data, wd_rsp_err} !== {IDW'(g), 128'h0, 1'b1}) begin
         n_bad++; $display("FAIL wd_expiry_rsp: got id=%0d data=%h err=%b want %0d 0 1", wd_rsp_id, wd_rsp_data, wd_rsp_err, g); end
      @(negedge clk);
      // normal request afterwards
      lane = $urandom_range(0, REQ-1); x = rand128(); val = rand128();
      wd_req_x[lane*K +: K] = x; wd_req_valid = onehot(lane);
      #1;
      g = ref_grant(wd_req_valid, wd_ptr);
      n_cmp++; if (wd_req_ready !== onehot(g)) begin
         n_bad++; $display("FAIL wd_grant2: got %b want %b", wd_req_ready, onehot(g)); end
      wd_ptr = (g + 1) % REQ;
      @(negedge clk); wd_req_valid = '0;
      @(negedge clk);
      n_cmp++; if ({wd_l_x_valid, wd_l_x} !== {1'b1, x}) begin
         n_bad++; $display("FAIL wd_load2: got xv=%b x=%h want 1 %h", wd_l_x_valid, wd_l_x, x); end
      repeat (3) @(negedge clk);
      wd_l_out = val; wd_l_out_valid = 1'b1;
      @(negedge clk); wd_l_out_valid = 1'b0;
      n_cmp++; if ({wd_rsp_valid, wd_rsp_id, wd_rsp_data, wd_rsp_err} !== {1'b1, IDW'(g), val, 1'b0}) begin
         n_bad++; $display("FAIL wd_normal_rsp: got v=%b id=%0d data=%h err=%b want 1 %0d %h 0", wd_rsp_valid, wd_rsp_id, wd_rsp_data, wd_rsp_err, g, val); end
      @(negedge clk);
      // result coinciding with the expiry cycle
      lane = $urandom_range(0, REQ-1); x = rand128(); val = rand128();
      wd_req_x[lane*K +: K] = x; wd_req_valid = onehot(lane);
      #1;
      g = ref_grant(wd_req_valid, wd_ptr);
      wd_ptr = (g + 1) % REQ;
      @(negedge clk); wd_req_valid = '0;
      repeat (17) @(negedge clk);
      n_cmp++; if (wd_rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL wd_early: got rsp_valid=%b want 0", wd_rsp_valid); end
      wd_l_out = val; wd_l_out_valid = 1'b1;
      @(negedge clk); wd_l_out_valid = 1'b0;
      n_cmp++; if ({wd_rsp_valid, wd_rsp_id, wd_rsp_data, wd_rsp_err} !== {1'b1, IDW'(g), val, 1'b0}) begin
         n_bad++; $display("FAIL wd_coincide: got v=%b id=%0d data=%h err=%b want 1 %0d %h 0", wd_rsp_valid, wd_rsp_id, wd_rsp_data, wd_rsp_err, g, val); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic [K-1:0] x;
      int g, n; bit ok;
      x = rand128();
      req_x[3*K +: K] = x; req_valid = 4'b1000; mdl_lat = 50; rsp_ready = 1'b1;
      #1;
      g = ref_grant(req_valid, ref_ptr);
      ref_ptr = (g + 1) % REQ;
      @(negedge clk); req_valid = '0;
      repeat (5) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin
         n_bad++; $display("FAIL rmid_busy: got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({rsp_valid, rsp_id, rsp_err, busy, l_task_start, l_x_valid, rsp_data, l_x} !== '0) begin
         n_bad++; $display("FAIL rmid_async: got %h want 0", {rsp_valid, rsp_id, rsp_err, busy, l_task_start, l_x_valid, rsp_data, l_x}); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; ref_ptr = 0; wd_ptr = 0;
      for (int i = 0; i < REQ; i++) req_x[i*K +: K] = rand128();
      x = req_x[0 +: K];
      req_valid = '1; mdl_lat = 3;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin
         n_bad++; $display("FAIL rmid_first_grant: got %b want 0001", req_ready); end
      ref_ptr = 1;
      @(negedge clk); req_valid = '0;
      wait_rsp(40, n, ok);
      n_cmp++; if (!ok || {rsp_id, rsp_data, rsp_err} !== {2'd0, lfunc(x), 1'b0}) begin
         n_bad++; $display("FAIL rmid_rsp: got ok=%0d id=%0d data=%h err=%b want 1 0 %h 0", ok, rsp_id, rsp_data, rsp_err, lfunc(x)); end
      @(negedge clk);
   endtask

   task automatic test_random;
      logic [REQ-1:0] v;
      logic [K-1:0]   xs [REQ];
      int g, n, stall; bit ok;
      rsp_t exp;
      for (int t = 0; t < 25; t++) begin
         v = REQ'($urandom_range(1, (1 << REQ) - 1));
         for (int i = 0; i < REQ; i++) begin
            xs[i] = rand128();
            req_x[i*K +: K] = xs[i];
         end
         mdl_lat = $urandom_range(1, 12);
         stall   = $urandom_range(0, 3);
         rsp_ready = (stall == 0);
         req_valid = v;
         #1;
         g = ref_grant(v, ref_ptr);
         exp.id = IDW'(g); exp.data = lfunc(xs[g]); exp.err = 1'b0;
         n_cmp++; if (req_ready !== onehot(g)) begin
            n_bad++; $display("FAIL rand%0d_grant: got %b want %b", t, req_ready, onehot(g)); end
         ref_ptr = (g + 1) % REQ;
         @(negedge clk);
         n_cmp++; if ({req_ready, l_task_start} !== {4'b0000, 1'b1}) begin
            n_bad++; $display("FAIL rand%0d_start: got rdy=%b st=%b want 0000 1", t, req_ready, l_task_start); end
         wait_rsp(40, n, ok);
         n_cmp++; if (!ok || n != mdl_lat + 2) begin
            n_bad++; $display("FAIL rand%0d_latency: got ok=%0d n=%0d want 1 %0d", t, ok, n, mdl_lat + 2); end
         repeat (stall) @(negedge clk);
         n_cmp++; if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, exp}) begin
            n_bad++; $display("FAIL rand%0d_rsp: got v=%b id=%0d data=%h err=%b want 1 %0d %h 0", t, rsp_valid, rsp_id, rsp_data, rsp_err, exp.id, exp.data); end
         rsp_ready = 1'b1;
         @(negedge clk);
         n_cmp++; if ({busy, rsp_valid} !== 2'b00) begin
            n_bad++; $display("FAIL rand%0d_idle: got %b want 00", t, {busy, rsp_valid}); end
      end
      req_valid = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got simulation still running want finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_all_lanes();
      test_backpressure();
      test_spurious();
      test_watchdog();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/l_func_arbiter.md
# l_func_arbiter

Round-robin scheduler that shares one L-function unit (L(x) = (x−1)/n, K-bit operand, N-bit internal word) among REQ decryption lanes in the Paillier datapath. Accepts one operand at a time from the requesters, then sequences the unit's `task_start` / `L_x_valid` protocol. Waits for `L_out_valid`, and returns the result tagged with the originating lane ID. A watchdog converts a hung L-unit operation into an error response so a lane never stalls forever.

## Interface
- `K`, 128, operand/result width
- `N`, 32, L-unit word width (passed through for the paired L-unit instance; unused internally)
- `REQ`, 4, number of requesters (≥2)
- `TIMEOUT`, 4096, max WAIT cycles before error response
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock, reset asynchronous, active-low
- `req_valid`  in  REQ  per-lane request
- `req_x`  in  REQ×K  per-lane operand (packed, lane i at [i*K +: K])
- `req_ready`  out  REQ  one-hot grant/accept
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  $clog2(REQ)  originating lane
- `rsp_data`  out  K  L(x) result (0 on error)
- `rsp_err`  out  1  watchdog expired
- `busy`  out  1  state ≠ IDLE
- `l_task_start`  out  1  one-cycle start pulse to L unit
- `l_x`  out  K  operand to L unit
- `l_x_valid`  out  1  one-cycle operand-valid pulse
- `l_out`  in  K  L-unit result
- `l_out_valid`  in  1  L-unit result strobe

## Operation
- FSM: IDLE → START → LOAD → WAIT → RESP → IDLE.
- **IDLE**
  - Combinational grant: first lane with `req_valid` at or after `rr_ptr`, cyclically.
  - `req_ready` equals that one-hot grant.
  - On handshake: capture `req_x[g]` into `op_q` and `g` into `id_q`; set `rr_ptr` ← (g+1) mod REQ; go to START.
  - No `req_valid` → `req_ready` = 0, stay in IDLE.
- **START**: `l_task_start`=1 for exactly one cycle → LOAD.
- **LOAD**: `l_x_valid`=1 for exactly one cycle, with `l_x`=`op_q` → WAIT. Clear the watchdog.
- **WAIT**
  - On `l_out_valid`: capture `l_out` into `rsp_data`, set `rsp_err`=0 → RESP.
  - Otherwise increment the watchdog. When it reaches TIMEOUT−1 without `l_out_valid`: `rsp_data`=0, `rsp_err`=1 → RESP.
  - If `l_out_valid` coincides with the expiry cycle, the result wins (err=0).
- **RESP**: `rsp_valid`=1, `rsp_id`=`id_q`; hold all response fields stable until `rsp_ready`. On `rsp_valid`&&`rsp_ready` → IDLE.
- `l_out_valid` in any state other than WAIT is ignored and causes no state change.
- `req_ready` = 0 in every state except IDLE. Requests stay pending; no request is dropped.
- Watchdog counter width: $clog2(TIMEOUT); it saturates and never wraps.
- `rr_ptr` advances only on an accepted grant. This makes the arbiter starvation-free: any asserted lane is served within REQ grants.

## Timing
- Reset values: FSM=IDLE, `rr_ptr`=0, watchdog=0, `op_q`=0, `id_q`=0.
- Output reset values: `req_ready`=0 while `req_valid`=0, `l_task_start`=0, `l_x`=0, `l_x_valid`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0.
- All outputs except `req_ready` are registered.
- Accept at cycle T:
  - `l_task_start` at T+1.
  - `l_x_valid`/`l_x` at T+2.
  - WAIT from T+3.
- `l_out_valid` at cycle W → `rsp_valid` at W+1.
- `rsp_ready` held high: back in IDLE at W+2, where the next accept can occur.
- Minimum spacing between accepts: L latency + 4 cycles.
- Reset asserted mid-operation: immediate return to reset values. An in-flight L-unit result is discarded; the L unit is restarted by the next `l_task_start`.

## Structure
- Package `l_arb_pkg`:
  - FSM state enum (IDLE, START, LOAD, WAIT, RESP).
  - Default localparams for K, REQ, TIMEOUT.
  - Response struct {id, data, err}.
- Sub-module `rr_arbiter` (REQ-wide, combinational round-robin grant from request vector + pointer, plus pointer-update output).
  - Reused elsewhere for modexp lane sharing.
- The L unit itself is instantiated by the parent, not inside this block.

## Test plan
- **Single request**: lane 2, x=0x…0A3, L unit model returns 0x55 after 20 cycles.
  - `l_task_start` at T+1, `l_x_valid` at T+2 with `l_x`=0x…0A3.
  - `rsp_valid` 21 cycles after LOAD+1, with `rsp_id`=2, `rsp_data`=0x55, `rsp_err`=0.
- **All 4 lanes asserted continuously from reset** → grant order 0,1,2,3,0; each `rsp_id` matches its grant.
- **Backpressure**: `rsp_ready`=0 for 10 cycles in RESP.
  - `rsp_*` stable throughout; `req_ready`=0; no second `l_task_start`.
- **Watchdog**: L model never responds, TIMEOUT=16.
  - `rsp_valid` with `rsp_err`=1 and `rsp_data`=0 exactly 16 WAIT cycles after entry; next request is served normally.
- **Spurious strobe**: `l_out_valid` pulsed in IDLE and in START → ignored; the correct result is still delivered later.
- **Reset mid-WAIT**: all outputs return to reset values; after release, lane 0 is granted first (`rr_ptr`=0).
